// File: rtl/axil_periph_demux.sv
// AXI4-Lite 1-to-N peripheral demux: fixed equal-size windows per slave,
// unmapped accesses answered locally with DECERR and counted (saturating).
module axil_periph_demux #(
  parameter  int N_SLAVES   = 4,
  parameter  int ADDR_WIDTH = 24,
  parameter  int DATA_WIDTH = 32,
  parameter  int WIN_WIDTH  = 16,
  localparam int STRB       = DATA_WIDTH/8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB-1:0]                wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [WIN_WIDTH-1:0]           m_awaddr,
  output logic [2:0]                     m_awprot,
  output logic [DATA_WIDTH-1:0]          m_wdata,
  output logic [STRB-1:0]                m_wstrb,
  output logic [WIN_WIDTH-1:0]           m_araddr,
  output logic [2:0]                     m_arprot,
  output logic [N_SLAVES-1:0]            m_awvalid,
  input  logic [N_SLAVES-1:0]            m_awready,
  output logic [N_SLAVES-1:0]            m_wvalid,
  input  logic [N_SLAVES-1:0]            m_wready,
  input  logic [N_SLAVES-1:0]            m_bvalid,
  output logic [N_SLAVES-1:0]            m_bready,
  output logic [N_SLAVES-1:0]            m_arvalid,
  input  logic [N_SLAVES-1:0]            m_arready,
  input  logic [N_SLAVES-1:0]            m_rvalid,
  output logic [N_SLAVES-1:0]            m_rready,
  input  logic [2*N_SLAVES-1:0]          m_bresp,
  input  logic [DATA_WIDTH*N_SLAVES-1:0] m_rdata,
  input  logic [2*N_SLAVES-1:0]          m_rresp,
  output logic [15:0]                    decerr_count
);
  localparam int IW = ADDR_WIDTH - WIN_WIDTH;
  localparam int XW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  typedef logic [N_SLAVES-1:0] vec_t;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BACK} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_BACK} r_state_e;

  function automatic vec_t onehot(input logic [XW-1:0] i);
    onehot = vec_t'(1) << i;
  endfunction

  logic [N_SLAVES-1:0][1:0]            s_bresp, s_rresp;
  logic [N_SLAVES-1:0][DATA_WIDTH-1:0] s_rdata;
  assign s_bresp = m_bresp;
  assign s_rresp = m_rresp;
  assign s_rdata = m_rdata;

  logic [IW-1:0] aw_blk, ar_blk;
  logic          aw_hit, ar_hit;
  assign aw_blk = awaddr[ADDR_WIDTH-1:WIN_WIDTH];
  assign ar_blk = araddr[ADDR_WIDTH-1:WIN_WIDTH];
  assign aw_hit = 32'(aw_blk) < 32'(N_SLAVES);
  assign ar_hit = 32'(ar_blk) < 32'(N_SLAVES);

  w_state_e              w_state_q, w_state_d;
  logic [XW-1:0]         w_idx_q, w_idx_d;
  logic [WIN_WIDTH-1:0]  m_awaddr_q, m_awaddr_d;
  logic [2:0]            m_awprot_q, m_awprot_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [STRB-1:0]       m_wstrb_q, m_wstrb_d;
  vec_t                  m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
  vec_t                  m_bready_q, m_bready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic [XW-1:0]         r_idx_q, r_idx_d;
  logic [WIN_WIDTH-1:0]  m_araddr_q, m_araddr_d;
  logic [2:0]            m_arprot_q, m_arprot_d;
  vec_t                  m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [15:0] cnt_q, cnt_d;
  logic        w_acc, r_acc, w_decerr, r_decerr;
  logic [16:0] cnt_sum;

  // Gated by reset so the upstream readies read 0 while reset is held.
  assign w_acc = (w_state_q == W_IDLE) && awvalid && wvalid && rst;
  assign r_acc = (r_state_q == R_IDLE) && arvalid && rst;

  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    m_awaddr_d  = m_awaddr_q;
    m_awprot_d  = m_awprot_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    w_decerr    = 1'b0;
    case (w_state_q)
      W_IDLE: if (w_acc) begin
        w_idx_d    = aw_blk[XW-1:0];
        m_awaddr_d = awaddr[WIN_WIDTH-1:0];
        m_awprot_d = awprot;
        m_wdata_d  = wdata;
        m_wstrb_d  = wstrb;
        if (aw_hit) begin
          m_awvalid_d = onehot(aw_blk[XW-1:0]);
          m_wvalid_d  = onehot(aw_blk[XW-1:0]);
          w_state_d   = W_FWD;
        end else begin
          bvalid_d  = 1'b1;
          bresp_d   = 2'b11;
          w_decerr  = 1'b1;
          w_state_d = W_BACK;
        end
      end
      W_FWD: begin
        // AW and W retire independently; move on once both have handshaken.
        m_awvalid_d = m_awvalid_q & ~m_awready;
        m_wvalid_d  = m_wvalid_q & ~m_wready;
        if (m_awvalid_d == '0 && m_wvalid_d == '0) begin
          m_bready_d = onehot(w_idx_q);
          w_state_d  = W_RESP;
        end
      end
      W_RESP: if ((m_bvalid & m_bready_q) != '0) begin
        m_bready_d = '0;
        bvalid_d   = 1'b1;
        bresp_d    = s_bresp[w_idx_q];
        w_state_d  = W_BACK;
      end
      W_BACK: if (bready) begin
        bvalid_d  = 1'b0;
        bresp_d   = 2'b00;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_idx_d     = r_idx_q;
    m_araddr_d  = m_araddr_q;
    m_arprot_d  = m_arprot_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    r_decerr    = 1'b0;
    case (r_state_q)
      R_IDLE: if (r_acc) begin
        r_idx_d    = ar_blk[XW-1:0];
        m_araddr_d = araddr[WIN_WIDTH-1:0];
        m_arprot_d = arprot;
        if (ar_hit) begin
          m_arvalid_d = onehot(ar_blk[XW-1:0]);
          r_state_d   = R_FWD;
        end else begin
          rvalid_d  = 1'b1;
          rresp_d   = 2'b11;
          rdata_d   = '0;
          r_decerr  = 1'b1;
          r_state_d = R_BACK;
        end
      end
      R_FWD: begin
        m_arvalid_d = m_arvalid_q & ~m_arready;
        if (m_arvalid_d == '0) begin
          m_rready_d = onehot(r_idx_q);
          r_state_d  = R_RESP;
        end
      end
      R_RESP: if ((m_rvalid & m_rready_q) != '0) begin
        m_rready_d = '0;
        rvalid_d   = 1'b1;
        rresp_d    = s_rresp[r_idx_q];
        rdata_d    = s_rdata[r_idx_q];
        r_state_d  = R_BACK;
      end
      R_BACK: if (rready) begin
        rvalid_d  = 1'b0;
        rresp_d   = 2'b00;
        rdata_d   = '0;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Both paths can hit DECERR in one cycle, so the step is 0..2.
  assign cnt_sum = {1'b0, cnt_q} + {15'd0, w_decerr} + {15'd0, r_decerr};
  assign cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      m_awaddr_q  <= '0;
      m_awprot_q  <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      m_bready_q  <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      r_state_q   <= R_IDLE;
      r_idx_q     <= '0;
      m_araddr_q  <= '0;
      m_arprot_q  <= '0;
      m_arvalid_q <= '0;
      m_rready_q  <= '0;
      rvalid_q    <= 1'b0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      m_awaddr_q  <= m_awaddr_d;
      m_awprot_q  <= m_awprot_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      m_araddr_q  <= m_araddr_d;
      m_arprot_q  <= m_arprot_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign awready      = w_acc;
  assign wready       = w_acc;
  assign arready      = r_acc;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign rvalid       = rvalid_q;
  assign rresp        = rresp_q;
  assign rdata        = rdata_q;
  assign m_awaddr     = m_awaddr_q;
  assign m_awprot     = m_awprot_q;
  assign m_wdata      = m_wdata_q;
  assign m_wstrb      = m_wstrb_q;
  assign m_araddr     = m_araddr_q;
  assign m_arprot     = m_arprot_q;
  assign m_awvalid    = m_awvalid_q;
  assign m_wvalid     = m_wvalid_q;
  assign m_bready     = m_bready_q;
  assign m_arvalid    = m_arvalid_q;
  assign m_rready     = m_rready_q;
  assign decerr_count = cnt_q;
endmodule

// File: tb/tb_axil_periph_demux.sv
// Directed bench for axil_periph_demux with a simple reactive model of the
// four downstream slaves; every expected value is hand-derived.
module tb_axil_periph_demux;
  localparam int N = 4, AW = 24, DW = 32, WW = 16, SW = DW/8;

  logic clk = 1'b0, rst = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic [WW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [N-1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N-1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2*N-1:0]  m_bresp, m_rresp;
  logic [DW*N-1:0] m_rdata;
  logic [15:0]   decerr_count;

  logic [N-1:0][1:0]    bresp_cfg, rresp_cfg;
  logic [N-1:0][DW-1:0] rdata_cfg;
  logic [N-1:0] aw_rdy, w_rdy, ar_rdy, bhold, got_aw, got_w, got_ar;
  logic [WW-1:0] cap_awaddr [N];
  logic [DW-1:0] cap_wdata  [N];
  logic [SW-1:0] cap_wstrb  [N];

  int n_chk = 0, n_fail = 0;

  axil_periph_demux dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_bresp(m_bresp), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .decerr_count(decerr_count)
  );

  always #5 clk = ~clk;

  // Slave model: accept AW/W/AR per ready mask, respond once both AW and W are seen.
  assign m_awready = aw_rdy;
  assign m_wready  = w_rdy;
  assign m_arready = ar_rdy;
  assign m_bvalid  = got_aw & got_w & ~bhold;
  assign m_rvalid  = got_ar;
  assign m_bresp   = bresp_cfg;
  assign m_rresp   = rresp_cfg;
  assign m_rdata   = rdata_cfg;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      got_aw <= '0;
      got_w  <= '0;
      got_ar <= '0;
    end else begin
      got_aw <= (got_aw | (m_awvalid & m_awready)) & ~(m_bvalid & m_bready);
      got_w  <= (got_w  | (m_wvalid & m_wready))   & ~(m_bvalid & m_bready);
      got_ar <= (got_ar | (m_arvalid & m_arready)) & ~(m_rvalid & m_rready);
      for (int i = 0; i < N; i++) begin
        if (m_awvalid[i] && m_awready[i]) cap_awaddr[i] <= m_awaddr;
        if (m_wvalid[i] && m_wready[i]) begin
          cap_wdata[i] <= m_wdata;
          cap_wstrb[i] <= m_wstrb;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    bready = 1'b0; rready = 1'b0;
    aw_rdy = '1; w_rdy = '1; ar_rdy = '1; bhold = '0;
    bresp_cfg = '0; rresp_cfg = '0; rdata_cfg = '0;

    // Reset with requests pending: nothing may be accepted or driven.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (2) tick;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_resp", 32'({bvalid, rvalid, bresp, rresp}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mvalids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 0);
    chk("rst_cnt", 32'(decerr_count), 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst = 1'b1;
    tick;

    // AW alone is not accepted.
    awaddr = 24'h010000; awvalid = 1'b1;
    #1 chk("aw_only_ready", 32'({awready, wready}), 0);
    tick;
    chk("aw_only_fwd", 32'({m_awvalid, m_wvalid}), 0);
    awvalid = 1'b0;

    // Mapped write to slave 1, zero-wait.
    bready = 1'b1;
    awaddr = 24'h010004; awprot = 3'b010; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    #1 chk("wr_accept", 32'({awready, wready}), 3);
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_m_awvalid", 32'(m_awvalid), 'b0010);
    chk("wr_m_wvalid", 32'(m_wvalid), 'b0010);
    chk("wr_m_awaddr", 32'(m_awaddr), 'h0004);
    chk("wr_m_awprot", 32'(m_awprot), 2);
    chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("wr_m_wstrb", 32'(m_wstrb), 'hF);
    tick;
    chk("wr_m_bready", 32'({m_awvalid, m_bready, bvalid}), 'b0000_0010_0);
    tick;
    chk("wr_bvalid", 32'({bvalid, bresp}), 'b100);
    chk("wr_slave_data", cap_wdata[1], 32'hDEADBEEF);
    tick;
    chk("wr_done", 32'({bvalid, decerr_count}), 0);

    // Mapped read from slave 3, SLVERR passed through.
    rdata_cfg[3] = 32'h12345678; rresp_cfg[3] = 2'b10; rready = 1'b1;
    araddr = 24'h030010; arprot = 3'b001; arvalid = 1'b1;
    #1 chk("rd_accept", 32'(arready), 1);
    tick;
    arvalid = 1'b0;
    chk("rd_m_arvalid", 32'(m_arvalid), 'b1000);
    chk("rd_m_araddr", 32'(m_araddr), 'h0010);
    chk("rd_m_arprot", 32'(m_arprot), 1);
    tick;
    chk("rd_m_rready", 32'(m_rready), 'b1000);
    tick;
    chk("rd_rvalid", 32'({rvalid, rresp}), 'b110);
    chk("rd_rdata", rdata, 32'h12345678);
    tick;
    chk("rd_done", 32'(rvalid), 0);

    // Unmapped read then unmapped write.
    araddr = 24'h050000; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    chk("ur_resp", 32'({rvalid, rresp}), 'b111);
    chk("ur_rdata", rdata, 0);
    chk("ur_no_fwd", 32'(m_arvalid), 0);
    chk("ur_cnt", 32'(decerr_count), 1);
    tick;
    awaddr = 24'h0F0000; awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("uw_resp", 32'({bvalid, bresp}), 'b111);
    chk("uw_no_fwd", 32'({m_awvalid, m_wvalid}), 0);
    chk("uw_cnt", 32'(decerr_count), 2);
    tick;

    // Backpressure: slave 0 holds AW off for 5 cycles, upstream holds bready low.
    aw_rdy = 4'b1110; bresp_cfg[0] = 2'b01; bready = 1'b0;
    awaddr = 24'h000020; wdata = 32'h0BADF00D; wstrb = 4'h3;
    awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_both_valid", 32'({m_awvalid, m_wvalid}), 'h11);
    tick;
    chk("bp_w_dropped", 32'({m_awvalid, m_wvalid}), 'h10);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("bp_aw_hold", 32'({m_awvalid, m_bready}), 'h10);
    end
    aw_rdy = '1;
    tick;
    chk("bp_aw_done", 32'({m_awvalid, m_bready}), 'h01);
    chk("bp_slave_addr", 32'(cap_awaddr[0]), 'h0020);
    chk("bp_slave_data", cap_wdata[0], 32'h0BADF00D);
    chk("bp_slave_strb", 32'(cap_wstrb[0]), 3);
    tick;
    chk("bp_bvalid", 32'({bvalid, bresp}), 'b101);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp_b_stable", 32'({bvalid, bresp}), 'b101);
    end
    bready = 1'b1;
    tick;
    chk("bp_b_done", 32'(bvalid), 0);

    // Concurrent read and write to slave 2.
    rdata_cfg[2] = 32'hA5A55A5A; rresp_cfg[2] = 2'b00; bresp_cfg[2] = 2'b00;
    araddr = 24'h020008; awaddr = 24'h02000C; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("cc_fwd", 32'({m_awvalid, m_arvalid}), 'h44);
    chk("cc_addr", {m_awaddr, m_araddr}, 32'h000C_0008);
    tick;
    tick;
    chk("cc_resp", 32'({bvalid, bresp, rvalid, rresp}), 'b100100);
    chk("cc_rdata", rdata, 32'hA5A55A5A);
    chk("cc_slave_data", cap_wdata[2], 32'hCAFEF00D);
    tick;

    // Reset while the write waits in W_RESP.
    bhold = 4'b0100;
    awaddr = 24'h020000; wdata = 32'h11112222; awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    tick;
    tick;
    chk("mr_in_resp", 32'({m_bready, bvalid}), 'b0100_0);
    rst = 1'b0;
    #1;
    chk("mr_outputs", 32'({m_bready, m_awvalid, m_wvalid, bvalid, rvalid}), 0);
    chk("mr_cnt", 32'(decerr_count), 0);
    chk("mr_bus", {m_awaddr, m_araddr}, 0);
    chk("mr_wdata", m_wdata, 0);
    bhold = '0;
    tick;
    rst = 1'b1;
    tick;
    awaddr = 24'h010040; wdata = 32'h33334444; awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    tick;
    tick;
    chk("pr_bvalid", 32'({bvalid, bresp}), 'b100);
    chk("pr_slave_data", cap_wdata[1], 32'h33334444);
    tick;
    chk("pr_done", 32'(bvalid), 0);

    // Saturation: unmapped read + write every 2 cycles, +2 each time.
    araddr = 24'h0F0000; awaddr = 24'h0F0000;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick;
    chk("sat_double_inc", 32'(decerr_count), 2);
    chk("sat_no_fwd", 32'({m_awvalid, m_wvalid, m_arvalid}), 0);
    repeat (65532) tick;
    chk("sat_fffe", 32'(decerr_count), 'hFFFE);
    repeat (2) tick;
    chk("sat_ffff", 32'(decerr_count), 'hFFFF);
    repeat (10) tick;
    chk("sat_hold", 32'(decerr_count), 'hFFFF);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (2) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_periph_demux.md
# axil_periph_demux

Parametrised AXI4-Lite 1-to-N peripheral demultiplexer that places up to N_SLAVES peripherals (UART, timers, GPIO, …) behind a single slave port on the peripheral bus. It decodes each read and write to a fixed, equal-sized address window per slave. Unmapped accesses are answered internally with DECERR, and a saturating counter records them. Read and write paths are independent, with one outstanding transaction per path.

## Interface
- N_SLAVES, default 4: number of downstream AXI-Lite slaves, 1..16.
- ADDR_WIDTH, default 24: upstream address width.
- DATA_WIDTH, default 32: data width; STRB = DATA_WIDTH/8.
- WIN_WIDTH, default 16: per-slave window is 2^WIN_WIDTH bytes; slave i occupies [i<<WIN_WIDTH, (i+1)<<WIN_WIDTH).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- Upstream AXI-Lite slave: awaddr in ADDR_WIDTH, awprot in 3, awvalid in 1, awready out 1, wdata in DATA_WIDTH, wstrb in STRB, wvalid in 1, wready out 1, bresp out 2, bvalid out 1, bready in 1, araddr in ADDR_WIDTH, arprot in 3, arvalid in 1, arready out 1, rdata out DATA_WIDTH, rresp out 2, rvalid out 1, rready in 1.
- Downstream m_* master ports. Broadcast signals, shared by all slaves: m_awaddr out WIN_WIDTH, m_awprot out 3, m_wdata out DATA_WIDTH, m_wstrb out STRB, m_araddr out WIN_WIDTH, m_arprot out 3.
- Downstream per-slave vectors, N_SLAVES bits (bit i is slave i): m_awvalid out, m_awready in, m_wvalid out, m_wready in, m_bvalid in, m_bready out, m_arvalid out, m_arready in, m_rvalid in, m_rready out.
- Downstream response buses, flattened with slave i at slice i: m_bresp in 2*N_SLAVES, m_rdata in DATA_WIDTH*N_SLAVES, m_rresp in 2*N_SLAVES.
- decerr_count  out  16  saturating count of DECERR responses issued (reads plus writes).

## Operation
- Decode: index = addr[ADDR_WIDTH-1:WIN_WIDTH]. Index < N_SLAVES selects slave index. Otherwise the access is unmapped. Forwarded address = addr[WIN_WIDTH-1:0].
- Write FSM states: W_IDLE, W_FWD, W_RESP, W_BACK.
  - W_IDLE: awready = wready = awvalid & wvalid (combinational), so AW and W are accepted together in the same cycle. On accept, register address, prot, data, strb and the decoded index. Mapped goes to W_FWD. Unmapped goes to W_BACK with bresp=2'b11.
  - W_FWD: m_awvalid[idx] and m_wvalid[idx] are asserted. Each drops independently after its own handshake. When both handshakes are done, go to W_RESP.
  - W_RESP: m_bready[idx]=1. On m_bvalid[idx], capture m_bresp slice and go to W_BACK.
  - W_BACK: bvalid=1, bresp held. On bready, return to W_IDLE.
- Read FSM states: R_IDLE, R_FWD, R_RESP, R_BACK. These mirror the write FSM.
  - arready = arvalid in R_IDLE.
  - R_FWD drives m_arvalid[idx].
  - R_RESP drives m_rready[idx] and captures the rdata/rresp slice.
  - Unmapped reads go straight to R_BACK with rresp=2'b11, rdata=0.
- Only the selected slave's valid/ready bit is ever high; all other bits are 0.
- The read and write FSMs run concurrently and may target the same or different slaves.
- decerr_count increments by 1 per unmapped accept. It increments by 2 when an unmapped read and an unmapped write are accepted in the same cycle. It saturates at 0xFFFF and never wraps.

## Timing
- Reset (rst=0, asynchronous): both FSMs go to IDLE. All outputs are 0: awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, every m_* output, and decerr_count. Reset mid-transaction abandons it; no response is issued.
- Mapped write with a zero-wait slave: accept at cycle 0; m_awvalid/m_wvalid at cycle 1; m_bready at cycle 2; bvalid at cycle 3 (minimum 3-cycle latency). Reads are identical: accept at 0, rvalid at 3.
- Unmapped access: accept at cycle 0, bvalid/rvalid at cycle 1.
- A new upstream transaction is not accepted until the cycle after the bready/rready handshake, so back-to-back throughput is 4 cycles per transaction minimum.
- AW-only or W-only presented in W_IDLE: nothing is accepted and both readies stay 0 until both valids are present.
- Downstream stalls (ready/bvalid/rvalid low) hold the FSM in its state indefinitely. There is no timeout.
- Upstream bready/rready held low keeps bvalid/rvalid and their payload stable.
- All m_* outputs are registered, with no combinational path from m_* inputs to m_* outputs.

## Test plan
- Mapped write: awaddr=0x010004, wdata=0xDEADBEEF, wstrb=0xF, slave 1 zero-wait OKAY -> m_awvalid=4'b0010, m_awaddr=0x0004, m_wdata=0xDEADBEEF, bresp=00, bvalid 3 cycles after accept, decerr_count=0.
- Mapped read: araddr=0x030010, slave 3 returns rdata=0x12345678 with rresp=10 -> m_araddr=0x0010, rdata=0x12345678, rresp=10 upstream.
- Unmapped: N_SLAVES=4, araddr=0x050000, then a write to 0x0F0000 -> rresp=11 with rdata=0, bresp=11, each response one cycle after accept, no m_* valid asserted, decerr_count=2.
- Backpressure: slave 0 holds m_awready low 5 cycles while m_wready=1 -> m_wvalid drops after its handshake, m_awvalid stays high until accepted; upstream bready low 3 cycles -> bvalid and bresp stable.
- Concurrency and reset: simultaneous read of slave 2 and write of slave 2 both complete with correct data. Then rst asserted while the write FSM is in W_RESP -> all outputs are 0 immediately, and the next write completes normally.
- Saturation: 65537 unmapped reads -> decerr_count holds at 0xFFFF.
